multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/ctrl_pkg.sv | 66 ++++++
 rtl/alu_decoder.sv | 24 ++
 rtl/multicycle_control.sv | 109 ++++++++++
 tb/tb_multicycle_control.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants, state enumeration and per-state control decode for the
// multicycle MIPS controller.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC_R, S_WB_R, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR
    } state_t;

    typedef struct packed {
        logic       instr_ready;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic [3:0] alu_control;
        logic       done;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{instr_ready: 1'b1, default: '0};

    // Control word for the state about to be entered; registering it makes
    // every output a clean flop decoded from state.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [3:0] r_alu,
                                       input logic wr_last, input logic ill);
        ctrl_t c;
        c = '0;
        case (s)
            S_IDLE:     begin c.instr_ready = 1'b1; c.illegal = ill; end
            S_EXEC_R:   c.alu_control = r_alu;
            S_WB_R:     begin
                c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_control = r_alu; c.done = 1'b1;
            end
            S_MEM_ADDR: begin c.alu_src = 1'b1; c.alu_control = ALU_ADD; end
            S_MEM_RD:   begin c.mem_read = 1'b1; c.alu_src = 1'b1; c.alu_control = ALU_ADD; end
            S_MEM_WB:   begin
                c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.mem_read = 1'b1;
                c.alu_src = 1'b1; c.done = 1'b1;
            end
            S_MEM_WR:   begin
                c.mem_write = 1'b1; c.alu_src = 1'b1; c.alu_control = ALU_ADD; c.done = wr_last;
            end
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps an R-type funct field to its ALU operation code and flags unsupported
// funct values.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       legal
);

    always_comb begin
        alu_control = ALU_AND;
        legal       = 1'b1;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle Moore control FSM for add/sub/and/or/slt, lw and sw. Handshake:
// an instruction is taken on a rising edge where instr_valid && instr_ready.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instruction,
    output logic        instr_ready,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        MemToReg,
    output logic [3:0]  ALUcontrol,
    output logic        done,
    output logic        illegal,
    output state_t      state_dbg
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state, state_next;
    logic [5:0] ir_op, ir_funct;
    logic [3:0] cnt, cnt_next;
    logic       ill_next;
    ctrl_t      ctrl_q, ctrl_next;
    logic [3:0] dec_alu;
    logic       dec_legal;

    // Register and immediate fields never steer control.
    logic unused_fields;
    assign unused_fields = ^instruction[25:6];

    alu_decoder u_alu_decoder (
        .funct       (ir_funct),
        .alu_control (dec_alu),
        .legal       (dec_legal)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ill_next   = 1'b0;
        case (state)
            S_IDLE:     if (instr_valid) state_next = S_DECODE;
            S_DECODE: begin
                if (ir_op == OP_RTYPE && dec_legal)      state_next = S_EXEC_R;
                else if (ir_op == OP_LW || ir_op == OP_SW) state_next = S_MEM_ADDR;
                else begin
                    state_next = S_IDLE;
                    ill_next   = 1'b1;
                end
            end
            S_EXEC_R:   state_next = S_WB_R;
            S_WB_R:     state_next = S_IDLE;
            S_MEM_ADDR: begin
                cnt_next   = '0;
                state_next = (ir_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                if (cnt == WAIT_LAST) state_next = S_MEM_WB;
                else                  cnt_next   = cnt + 4'd1;
            end
            S_MEM_WB:   state_next = S_IDLE;
            S_MEM_WR: begin
                if (cnt == WAIT_LAST) state_next = S_IDLE;
                else                  cnt_next   = cnt + 4'd1;
            end
            default:    state_next = S_IDLE;
        endcase
        ctrl_next = ctrl_for(state_next, dec_alu, cnt_next == WAIT_LAST, ill_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ir_op    <= '0;
            ir_funct <= '0;
            cnt      <= '0;
            ctrl_q   <= CTRL_RESET;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            ctrl_q <= ctrl_next;
            if (state == S_IDLE && instr_valid) begin
                ir_op    <= instruction[31:26];
                ir_funct <= instruction[5:0];
            end
        end
    end

    assign instr_ready = ctrl_q.instr_ready;
    assign RegDst      = ctrl_q.reg_dst;
    assign RegWrite    = ctrl_q.reg_write;
    assign ALUSrc      = ctrl_q.alu_src;
    assign MemWrite    = ctrl_q.mem_write;
    assign MemRead     = ctrl_q.mem_read;
    assign MemToReg    = ctrl_q.mem_to_reg;
    assign ALUcontrol  = ctrl_q.alu_control;
    assign done        = ctrl_q.done;
    assign illegal     = ctrl_q.illegal;
    assign state_dbg   = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (MEM_WAIT 0 and 2) checked every
// cycle against a per-instruction expected-cycle model, plus literal timing checks.
module tb_multicycle_control;

    localparam int W = 13;
    // Vector: {instr_ready, RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, ALUcontrol[3:0], done, illegal}
    localparam logic [W-1:0] IDLE_V = 13'b1_000000_0000_00;

    logic clk = 1'b0;
    logic rst_n;
    logic instr_valid;
    logic [31:0] instruction;
    logic [W-1:0] dut_v [2];
    logic [W-1:0] cur_exp [2];
    logic [W-1:0] exp_q0 [$];
    logic [W-1:0] exp_q1 [$];
    logic check_en = 1'b0;
    int errors = 0;
    int checks = 0;

    logic [5:0] good_fn [5];
    logic [5:0] bad_fn [6];
    logic [5:0] bad_op [6];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic rdy, rd, rw, as, mw, mr, mt, dn, il;
        logic [3:0] alu;
        logic [2:0] st;
        multicycle_control #(.MEM_WAIT(g == 0 ? 0 : 2)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .instr_valid (instr_valid),
            .instruction (instruction),
            .instr_ready (rdy),
            .RegDst      (rd),
            .RegWrite    (rw),
            .ALUSrc      (as),
            .MemWrite    (mw),
            .MemRead     (mr),
            .MemToReg    (mt),
            .ALUcontrol  (alu),
            .done        (dn),
            .illegal     (il),
            .state_dbg   (st)
        );
        assign dut_v[g] = {rdy, rd, rw, as, mw, mr, mt, alu, dn, il};
    end

    function automatic logic [W-1:0] mk(input bit rdy, input bit rd, input bit rw, input bit as,
                                        input bit mw, input bit mr, input bit mt,
                                        input logic [3:0] alu, input bit dn, input bit il);
        return {rdy, rd, rw, as, mw, mr, mt, alu, dn, il};
    endfunction

    function automatic bit r_alu(input logic [5:0] fn, output logic [3:0] alu);
        alu = 4'b0000;
        case (fn)
            6'b100000: alu = 4'b0101;
            6'b100010: alu = 4'b0110;
            6'b100100: alu = 4'b0000;
            6'b100101: alu = 4'b0001;
            6'b101010: alu = 4'b0111;
            default:   return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic push(input int k, input logic [W-1:0] v);
        if (k == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    // Expected outputs for every cycle after acceptance, straight from the
    // instruction class and the memory wait.
    task automatic push_seq(input int k, input logic [31:0] ins, input int w);
        logic [5:0] op;
        logic [3:0] alu;
        op = ins[31:26];
        push(k, mk(0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0));
        if (op == 6'b000000 && r_alu(ins[5:0], alu)) begin
            push(k, mk(0, 0, 0, 0, 0, 0, 0, alu, 0, 0));
            push(k, mk(0, 1, 1, 0, 0, 0, 0, alu, 1, 0));
        end else if (op == 6'b100011) begin
            push(k, mk(0, 0, 0, 1, 0, 0, 0, 4'b0101, 0, 0));
            for (int i = 0; i <= w; i++) push(k, mk(0, 0, 0, 1, 0, 1, 0, 4'b0101, 0, 0));
            push(k, mk(0, 0, 1, 1, 0, 1, 1, 4'd0, 1, 0));
        end else if (op == 6'b101011) begin
            push(k, mk(0, 0, 0, 1, 0, 0, 0, 4'b0101, 0, 0));
            for (int i = 0; i <= w; i++) push(k, mk(0, 0, 0, 1, 1, 0, 0, 4'b0101, i == w, 0));
        end else begin
            push(k, mk(1, 0, 0, 0, 0, 0, 0, 4'd0, 0, 1));
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
            cur_exp[0] <= IDLE_V;
            cur_exp[1] <= IDLE_V;
        end else begin
            for (int k = 0; k < 2; k++)
                if (cur_exp[k][12] && instr_valid) push_seq(k, instruction, k == 0 ? 0 : 2);
            cur_exp[0] <= (exp_q0.size() > 0) ? exp_q0.pop_front() : IDLE_V;
            cur_exp[1] <= (exp_q1.size() > 0) ? exp_q1.pop_front() : IDLE_V;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dut_v[k] !== cur_exp[k]) begin
                    errors++;
                    $display("FAIL outputs[%0d] t=%0t got=%b exp=%b", k, $time, dut_v[k], cur_exp[k]);
                end
                checks++;
                if (dut_v[k][10] && dut_v[k][8]) begin
                    errors++;
                    $display("FAIL write_excl[%0d] t=%0t got=%b exp=no RegWrite&MemWrite", k, $time, dut_v[k]);
                end
            end
        end
    end

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
        end
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // One instruction with hand-computed cycle numbers for both instances.
    task automatic directed(input string name, input logic [31:0] ins,
                            input int d0, input int d1, input int r0, input int r1,
                            input int w0, input int w1, input int ill);
        int dc [2];
        int rc [2];
        int wc [2];
        int ic [2];
        for (int k = 0; k < 2; k++) begin dc[k] = 0; rc[k] = 0; wc[k] = 0; ic[k] = 0; end
        @(negedge clk);
        instruction = ins;
        instr_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                instr_valid = 1'b0;
                instruction = $urandom;
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                if (dut_v[k][1] && dc[k] == 0) dc[k] = c;
                if (dut_v[k][0] && ic[k] == 0) ic[k] = c;
                if (dut_v[k][7] && !dut_v[k][10]) rc[k]++;
                if (dut_v[k][8]) wc[k]++;
            end
        end
        check_int({name, "_done0"}, dc[0], d0);
        check_int({name, "_done1"}, dc[1], d1);
        check_int({name, "_memrd0"}, rc[0], r0);
        check_int({name, "_memrd1"}, rc[1], r1);
        check_int({name, "_memwr0"}, wc[0], w0);
        check_int({name, "_memwr1"}, wc[1], w1);
        check_int({name, "_illegal0"}, ic[0], ill);
        check_int({name, "_illegal1"}, ic[1], ill);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rs, rt, rd;
        logic [15:0] imm;
        int sel;
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); imm = 16'($urandom);
        sel = $urandom_range(0, 7);
        if (sel < 5)  return {6'b000000, rs, rt, rd, 5'd0, good_fn[sel]};
        if (sel == 5) return {6'b100011, rs, rt, imm};
        if (sel == 6) return {6'b101011, rs, rt, imm};
        if ($urandom_range(0, 1) == 1) return {bad_op[$urandom_range(0, 5)], rs, rt, imm};
        return {6'b000000, rs, rt, rd, 5'd0, bad_fn[$urandom_range(0, 5)]};
    endfunction

    initial begin
        good_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        bad_fn  = '{6'b000000, 6'b100001, 6'b100011, 6'b100110, 6'b101011, 6'b111111};
        bad_op  = '{6'b000100, 6'b001000, 6'b001101, 6'b111111, 6'b100010, 6'b101010};
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instruction = '0;
        @(negedge clk);
        check_en = 1'b1;
        @(negedge clk);
        #1;
        check_int("reset_state0", int'(dut_v[0]), int'(IDLE_V));
        check_int("reset_state1", int'(dut_v[1]), int'(IDLE_V));
        rst_n = 1'b1;

        // First acceptance on the first edge after release.
        directed("add", 32'h00430820, 3, 3, 0, 0, 0, 0, 0);
        idle(4);
        directed("lw", 32'h8C440000, 4, 6, 1, 3, 0, 0, 0);
        idle(4);
        directed("sw", 32'hAC410000, 3, 5, 0, 0, 1, 3, 0);
        idle(4);
        directed("beq", 32'h10000000, 0, 0, 0, 0, 0, 0, 2);
        idle(4);
        directed("fn0", 32'h00000000, 0, 0, 0, 0, 0, 0, 2);
        idle(4);

        // add held valid: accepted again the cycle after each done.
        begin
            int dn [2];
            dn[0] = 0; dn[1] = 0;
            @(negedge clk);
            instruction = 32'h00430820;
            instr_valid = 1'b1;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                #1;
                for (int k = 0; k < 2; k++) if (dut_v[k][1]) dn[k]++;
                if (c == 12) instr_valid = 1'b0;
            end
            check_int("held_add_done0", dn[0], 3);
            check_int("held_add_done1", dn[1], 3);
        end
        idle(6);

        // Asynchronous reset while lw sits in MEM_RD.
        @(negedge clk);
        instruction = 32'h8C440000;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_int("memrd_before_rst0", int'(dut_v[0][7]), 1);
        check_int("memrd_before_rst1", int'(dut_v[1][7]), 1);
        #1 rst_n = 1'b0;
        #1;
        check_int("async_rst0", int'(dut_v[0]), int'(IDLE_V));
        check_int("async_rst1", int'(dut_v[1]), int'(IDLE_V));
        @(negedge clk);
        #1 rst_n = 1'b1;
        idle(6);

        // Back-to-back add, lw, sw rotation with instr_valid held high.
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            instr_valid = 1'b1;
            case (c % 3)
                0:       instruction = 32'h00430820;
                1:       instruction = 32'h8C440000;
                default: instruction = 32'hAC410000;
            endcase
        end
        idle(8);

        // Random traffic, instruction changing every cycle, occasional resets.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            instr_valid = ($urandom_range(0, 3) != 0);
            instruction = rand_instr();
            if ($urandom_range(0, 79) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #1 rst_n = 1'b1;
            end
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
